// File: rtl/bp_pkg.sv
// Shared types and constants for the fetch-stage branch predictor.
// The BP_PERF_CNT_EN build option is consumed by branch_predictor.
package bp_pkg;

    // Widest tag needed: 30 PC bits above the byte offset minus the smallest
    // index (ENTRIES=4 -> IDX_W=2). Narrower tags are zero-extended into it.
    localparam int BP_TAG_W = 28;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } bp_ctr_t;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [31:0]         target;
    } bp_entry_t;

    localparam bp_ctr_t BP_CTR_RESET = WNT;

    function automatic logic bp_ctr_taken(input bp_ctr_t ctr);
        return (ctr == WT) || (ctr == ST);
    endfunction

endpackage

// File: rtl/bp_sat_ctr.sv
// Next-state function of the 2-bit saturating direction counter.
// SNT <-> WNT <-> WT <-> ST, one step per resolved branch.
module bp_sat_ctr
    import bp_pkg::*;
(
    input  bp_ctr_t i_ctr,
    input  logic    i_taken,
    output bp_ctr_t o_ctr
);

    always_comb begin
        o_ctr = i_ctr;
        case (i_ctr)
            SNT:     o_ctr = i_taken ? WNT : SNT;
            WNT:     o_ctr = i_taken ? WT  : SNT;
            WT:      o_ctr = i_taken ? ST  : WNT;
            ST:      o_ctr = i_taken ? ST  : WT;
            default: o_ctr = BP_CTR_RESET;
        endcase
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB + 2-bit counter branch predictor with E-stage update.
// Define BP_PERF_CNT_EN to build the resolved-branch / mispredict counters.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES = 64
) (
    input  logic        clk,
    input  logic        n_rst,
    input  logic [31:0] pc_f,
    input  logic        stall,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ex_pred_taken,
    input  logic [31:0] ex_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] perf_branches,
    output logic [31:0] perf_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    bp_entry_t r_btb [ENTRIES];
    bp_ctr_t   r_ctr [ENTRIES];

    logic [IDX_W-1:0]    w_f_idx;
    logic [IDX_W-1:0]    w_ex_idx;
    logic [BP_TAG_W-1:0] w_f_tag;
    logic [BP_TAG_W-1:0] w_ex_tag;
    bp_entry_t           w_f_entry;
    bp_entry_t           w_ex_entry;
    bp_ctr_t             w_f_ctr;
    bp_ctr_t             w_ex_ctr;
    bp_ctr_t             w_ctr_next;
    logic                w_f_hit;
    logic                w_ex_hit;
    logic                w_commit;
    logic                w_unused_bits;

    assign w_f_idx    = pc_f[IDX_W+1:2];
    assign w_f_tag    = BP_TAG_W'(pc_f[31:IDX_W+2]);
    assign w_ex_idx   = ex_pc[IDX_W+1:2];
    assign w_ex_tag   = BP_TAG_W'(ex_pc[31:IDX_W+2]);
    assign w_unused_bits = ^{pc_f[1:0], ex_pc[1:0]};

    // Prediction reads the registered tables, so a same-cycle update is seen next cycle.
    assign w_f_entry  = r_btb[w_f_idx];
    assign w_f_ctr    = r_ctr[w_f_idx];
    assign w_f_hit    = w_f_entry.valid && (w_f_entry.tag == w_f_tag);
    assign pred_taken  = w_f_hit && bp_ctr_taken(w_f_ctr);
    assign pred_target = pred_taken ? w_f_entry.target : pc_f + 32'd4;

    assign mispredict  = ex_valid && ((ex_taken != ex_pred_taken) ||
                                      (ex_taken && (ex_target != ex_pred_target)));
    assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

    assign w_ex_entry = r_btb[w_ex_idx];
    assign w_ex_ctr   = r_ctr[w_ex_idx];
    assign w_ex_hit   = w_ex_entry.valid && (w_ex_entry.tag == w_ex_tag);
    assign w_commit   = ex_valid && !stall;

    bp_sat_ctr u_sat_ctr (
        .i_ctr   (w_ex_ctr),
        .i_taken (ex_taken),
        .o_ctr   (w_ctr_next)
    );

    // A not-taken miss leaves the entry alone so a live branch is not evicted.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_btb[i] <= '0;
                r_ctr[i] <= BP_CTR_RESET;
            end
        end else if (w_commit) begin
            if (w_ex_hit) begin
                r_ctr[w_ex_idx] <= w_ctr_next;
                if (ex_taken) begin
                    r_btb[w_ex_idx].target <= ex_target;
                end
            end else if (ex_taken) begin
                r_btb[w_ex_idx] <= '{valid: 1'b1, tag: w_ex_tag, target: ex_target};
                r_ctr[w_ex_idx] <= WT;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    logic [31:0] r_perf_branches;
    logic [31:0] r_perf_mispredicts;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_perf_branches    <= '0;
            r_perf_mispredicts <= '0;
        end else if (w_commit) begin
            r_perf_branches <= r_perf_branches + 32'd1;
            if (mispredict) begin
                r_perf_mispredicts <= r_perf_mispredicts + 32'd1;
            end
        end
    end

    assign perf_branches    = r_perf_branches;
    assign perf_mispredicts = r_perf_mispredicts;
`else
    assign perf_branches    = 32'h0;
    assign perf_mispredicts = 32'h0;
`endif

endmodule
